freq_step_selector: RTL and testbench

Parametrised front-panel frequency setpoint controller for the generator datapath. It turns two raw push buttons (plus and minus) and a bank of decade-select switches into a bounded binary setpoint `frecv_sel`. Each button is synchronised and debounced, and holding a button auto-repeats. Every accepted change saturates at configurable limits and is flagged by a one-cycle `q_modif` pulse to the downstream divider/NCO.

---
 rtl/freq_step_selector.sv | 126 ++++++++++++
 tb/tb_freq_step_selector.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/freq_step_selector.sv
// freq_step_selector: debounced plus/minus buttons with auto-repeat drive a saturating decade-step setpoint
module freq_step_selector #(
    parameter int WIDTH   = 16,
    parameter int NDIG    = 4,
    parameter int MIN_F   = 1,
    parameter int MAX_F   = 9999,
    parameter int RST_F   = 1,
    parameter int DEB_CYC = 16,
    parameter int REP_DLY = 2_000_000,
    parameter int REP_PER = 500_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NDIG-1:0]  sw,
    input  logic             pshbtn_pl,
    input  logic             pshbtn_mi,
    output logic [WIDTH-1:0] frecv_sel,
    output logic             q_modif,
    output logic             lim_hit
);
    localparam int DW = $clog2(DEB_CYC);
    localparam int RM = REP_DLY > REP_PER ? REP_DLY : REP_PER;
    localparam int CW = RM > 1 ? $clog2(RM) : 1;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DELAY  = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;
    localparam logic [WIDTH:0] MINW = (WIDTH+1)'(MIN_F);
    localparam logic [WIDTH:0] MAXW = (WIDTH+1)'(MAX_F);

    logic [1:0]    raw, s1, s2, deb, deb_q, rise;
    logic [DW-1:0] dcnt [2];
    logic [1:0]    state;
    logic [CW-1:0] rcnt;
    logic          dir;
    logic          ev;
    logic [WIDTH:0] step, p, fw, nv;
    logic          up_hit, dn_hit, hit;

    assign raw  = {pshbtn_mi, pshbtn_pl};
    assign rise = deb & ~deb_q;
    assign fw   = {1'b0, frecv_sel};

    // Synchronise each button and accept a level change only after DEB_CYC stable samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 2; i++) dcnt[i] <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_q <= deb;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DW'(DEB_CYC-1)) begin
                    deb[i]  <= s2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + DW'(1);
                end
            end
        end
    end

    // Repeat FSM: one event per fresh single-button press, then after REP_DLY, then every REP_PER
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rcnt  <= '0;
            dir   <= 1'b0;
            ev    <= 1'b0;
        end else begin
            ev <= 1'b0;
            if (state == IDLE) begin
                if ((rise[0] && !deb[1]) || (rise[1] && !deb[0])) begin
                    state <= DELAY;
                    dir   <= rise[1];
                    ev    <= 1'b1;
                    rcnt  <= CW'(REP_DLY-1);
                end
            end else if (!deb[dir] || deb[~dir]) begin
                state <= IDLE;
            end else if (rcnt == '0) begin
                state <= REPEAT;
                ev    <= 1'b1;
                rcnt  <= CW'(REP_PER-1);
            end else begin
                rcnt <= rcnt - CW'(1);
            end
        end
    end

    // Step is 10^k for the highest set switch; later iterations override earlier ones
    always_comb begin
        step = '0;
        p    = (WIDTH+1)'(1);
        for (int k = 0; k < NDIG; k++) begin
            if (sw[k]) step = p;
            p = p * (WIDTH+1)'(10);
        end
    end

    // Saturating add/subtract in one extra bit so the bound test cannot wrap
    always_comb begin
        up_hit = fw + step > MAXW;
        dn_hit = fw < MINW + step;
        hit    = dir ? dn_hit : up_hit;
        nv     = dir ? (dn_hit ? MINW : fw - step) : (up_hit ? MAXW : fw + step);
    end

    // Commit the new setpoint and raise the one-cycle change and limit pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frecv_sel <= WIDTH'(RST_F);
            q_modif   <= 1'b0;
            lim_hit   <= 1'b0;
        end else begin
            q_modif <= ev && (|sw) && (nv != fw);
            lim_hit <= ev && (|sw) && hit;
            if (ev && (|sw)) frecv_sel <= nv[WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_freq_step_selector.sv
// tb_freq_step_selector: directed button sequences with a scoreboard of expected setpoint updates
module tb_freq_step_selector;
    localparam int DEB = 4;

    typedef struct {
        int cyc;
        int f;
        bit q;
        bit l;
    } ev_t;

    logic        clk;
    logic        reset;
    logic [3:0]  sw;
    logic        pshbtn_pl;
    logic        pshbtn_mi;
    logic [15:0] frecv_sel;
    logic        q_modif;
    logic        lim_hit;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    int  mf = 1;
    ev_t sb[$];

    freq_step_selector #(
        .DEB_CYC(DEB),
        .REP_DLY(20),
        .REP_PER(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw(sw),
        .pshbtn_pl(pshbtn_pl),
        .pshbtn_mi(pshbtn_mi),
        .frecv_sel(frecv_sel),
        .q_modif(q_modif),
        .lim_hit(lim_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: push the expected result of one step event at update cycle c
    task automatic push_ev(input int c, input bit dn, input logic [3:0] s);
        int st;
        int nv;
        bit l;
        ev_t e;
        if (s == 4'b0000) return;
        st = 1;
        for (int i = 0; i < 4; i++) if (s[i]) st = 10 ** i;
        l = dn ? (mf < 1 + st) : (mf + st > 9999);
        nv = dn ? (l ? 1 : mf - st) : (l ? 9999 : mf + st);
        e.cyc = c;
        e.f = nv;
        e.q = (nv != mf);
        e.l = l;
        sb.push_back(e);
        mf = nv;
    endtask

    // Press one button for h cycles; events at +8, then +28, +36, ... while the debounced level holds
    task automatic press(input bit dn, input logic [3:0] s, input int h);
        int p;
        sw = s;
        if (dn) pshbtn_mi = 1'b1;
        else pshbtn_pl = 1'b1;
        p = cyc;
        push_ev(p + 8, dn, s);
        for (int t = 28; t <= h + DEB + 3; t += 8) push_ev(p + t, dn, s);
        tick(h);
        pshbtn_pl = 1'b0;
        pshbtn_mi = 1'b0;
        tick(14);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        #1;
        chk("reset_freq", 32'(frecv_sel), 32'(1));
        chk("reset_q", 32'(q_modif), 32'(0));
        chk("reset_lim", 32'(lim_hit), 32'(0));
        tick(n);
        reset = 1'b0;
        mf = 1;
    endtask

    initial begin
        int r;
        reset = 1'b1;
        sw = 4'b0000;
        pshbtn_pl = 1'b0;
        pshbtn_mi = 1'b0;
        fork
            forever begin
                ev_t e;
                @(negedge clk);
                if (!reset && (q_modif || lim_hit)) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pulse", 32'({q_modif, lim_hit}), 32'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("ev_cycle", 32'(cyc), 32'(e.cyc));
                        chk("ev_freq", 32'(frecv_sel), 32'(e.f));
                        chk("ev_q", 32'(q_modif), 32'(e.q));
                        chk("ev_lim", 32'(lim_hit), 32'(e.l));
                    end
                end
            end
        join_none

        do_reset(3);
        tick(2);
        press(1'b0, 4'b0100, 10);
        chk("single_press", 32'(frecv_sel), 32'(101));

        repeat (9) press(1'b0, 4'b1000, 10);
        repeat (8) press(1'b0, 4'b0100, 10);
        repeat (4) press(1'b0, 4'b0010, 10);
        repeat (9) press(1'b0, 4'b0001, 10);
        chk("climb_9950", 32'(frecv_sel), 32'(9950));
        press(1'b0, 4'b1000, 10);
        press(1'b0, 4'b1000, 10);
        chk("clamp_max", 32'(frecv_sel), 32'(9999));

        do_reset(2);
        tick(2);
        repeat (4) press(1'b0, 4'b0001, 10);
        chk("at_5", 32'(frecv_sel), 32'(5));
        press(1'b1, 4'b0011, 10);
        chk("clamp_min", 32'(frecv_sel), 32'(1));
        press(1'b0, 4'b0000, 10);
        chk("sw_zero", 32'(frecv_sel), 32'(1));

        press(1'b0, 4'b0001, 60);
        tick(30);
        chk("hold_repeat", 32'(frecv_sel), 32'(7));

        sw = 4'b0001;
        pshbtn_mi = 1'b1;
        tick(3);
        pshbtn_mi = 1'b0;
        tick(15);
        chk("glitch", 32'(frecv_sel), 32'(7));

        pshbtn_pl = 1'b1;
        pshbtn_mi = 1'b1;
        tick(15);
        pshbtn_pl = 1'b0;
        pshbtn_mi = 1'b0;
        tick(14);
        chk("both_buttons", 32'(frecv_sel), 32'(7));

        pshbtn_pl = 1'b1;
        push_ev(cyc + 8, 1'b0, 4'b0001);
        tick(12);
        pshbtn_mi = 1'b1;
        tick(28);
        pshbtn_pl = 1'b0;
        pshbtn_mi = 1'b0;
        tick(14);
        chk("abort_delay", 32'(frecv_sel), 32'(8));

        sw = 4'b0001;
        pshbtn_pl = 1'b1;
        r = cyc;
        push_ev(r + 8, 1'b0, 4'b0001);
        push_ev(r + 28, 1'b0, 4'b0001);
        push_ev(r + 36, 1'b0, 4'b0001);
        tick(40);
        do_reset(3);
        r = cyc;
        push_ev(r + 8, 1'b0, 4'b0001);
        tick(12);
        pshbtn_pl = 1'b0;
        tick(30);
        chk("reset_hold", 32'(frecv_sel), 32'(2));

        chk("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
